// File: rtl/bus_reader_fifo.sv
// -----------------------------------------------------------------------------
// bus_reader_fifo
//
// Receives words from a bus master over a 4-phase data_valid/data_read
// handshake, buffers them in a DEPTH-entry FIFO and presents them to a
// consumer on a valid/ready interface with first-word fall-through.
// When the FIFO is full the master is held off by withholding data_read.
// A master that drops data_valid while data_read is high is flagged on the
// sticky proto_err output.
//
// Parameters
//   DATA_W       width of bus words, FIFO entries and out_data
//   DEPTH        number of FIFO entries (power of 2, >= 2)
//   HOLD_CYCLES  cycles data_read stays high per transfer (>= 1)
//
// Ports
//   clk         in   rising-edge clock for all state
//   reset_n     in   asynchronous active-low reset
//   data_valid  in   bus master: word on data is valid
//   data        in   bus word
//   data_read   out  acknowledge to the bus master
//   out_valid   out  FIFO non-empty, out_data is valid
//   out_ready   in   consumer takes out_data this cycle
//   out_data    out  head of FIFO, zero when empty
//   count       out  number of entries held
//   full        out  count == DEPTH
//   proto_err   out  sticky handshake violation flag
//   err_clr     in   clears proto_err
// -----------------------------------------------------------------------------
module bus_reader_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         data_valid,
  input  logic [DATA_W-1:0]            data,
  output logic                         data_read,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         proto_err,
  input  logic                         err_clr
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);
  // ACK occupies HOLD_CYCLES-1 cycles, so its counter runs 0..HOLD_CYCLES-2.
  localparam int HOLD_LAST = (HOLD_CYCLES > 1) ? (HOLD_CYCLES - 2) : 0;
  localparam int HC_W      = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES - 1) : 1;

  typedef enum logic [1:0] {
    WAITING = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HC_W-1:0]   hold_cnt;
  logic [HC_W-1:0]   hold_cnt_nxt;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic              rd_en;
  logic              err_set;

  // ---------------------------------------------------------------------------
  // Input handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAITING;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      WAITING: begin
        // The full check is the only admission gate; with a single writer the
        // count cannot grow between this check and the write in CAPTURE.
        if (data_valid && !full) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        hold_cnt_nxt = '0;
        state_nxt    = (HOLD_CYCLES > 1) ? ACK : RELEASE;
      end
      ACK: begin
        if (hold_cnt == HC_W'(HOLD_LAST)) begin
          state_nxt = RELEASE;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!data_valid) begin
          state_nxt = WAITING;
        end
      end
      default: begin
        state_nxt = WAITING;
      end
    endcase
  end

  assign data_read = (state == CAPTURE) || (state == ACK);

  // The word is written on the edge that leaves CAPTURE.
  assign wr_en   = (state == CAPTURE);
  assign rd_en   = out_valid && out_ready;
  // The master must hold data_valid for the whole time data_read is high.
  assign err_set = data_read && !data_valid;

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data;
    end
  end

  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Sticky protocol error; a new violation outranks a clear in the same cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (err_set) begin
      proto_err <= 1'b1;
    end else if (err_clr) begin
      proto_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_reader_fifo.sv
module tb_bus_reader_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset_n;
  logic              data_valid;
  logic [DATA_W-1:0] data;
  logic              data_read;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              proto_err;
  logic              err_clr;

  int                n_vec;
  int                n_err;
  logic [DATA_W-1:0] sb [$];
  logic              track;
  int                max_cnt;

  bus_reader_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .HOLD_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_valid(data_valid),
    .data      (data),
    .data_read (data_read),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .proto_err (proto_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Pops are scored on the falling edge, where inputs are
  // stable; the caller resumes 1 time unit after the rising edge.
  task automatic cyc();
    logic [DATA_W-1:0] exp_w;
    @(negedge clk);
    if (track && int'(count) > max_cnt) max_cnt = int'(count);
    if (reset_n && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("pop_data", 32'(out_data), 32'(exp_w));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Full 4-phase transfer of one word, expected to be acknowledged promptly.
  task automatic xfer(input logic [DATA_W-1:0] d);
    int t;
    int hc;
    data       = d;
    data_valid = 1'b1;
    t = 0;
    cyc();
    while (!data_read && t < 20) begin
      cyc();
      t++;
    end
    check("ack_seen", 32'(data_read), 32'd1);
    sb.push_back(d);
    hc = 0;
    while (data_read && hc < 20) begin
      hc++;
      cyc();
    end
    check("ack_len", 32'(hc), 32'd2);
    data_valid = 1'b0;
    cyc();
  endtask

  task automatic drain();
    int k;
    out_ready = 1'b1;
    k = 0;
    while (count != '0 && k < 20) begin
      cyc();
      k++;
    end
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    check("drain_sb", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; track = 1'b0; max_cnt = 0;
    reset_n = 1'b0; data_valid = 1'b1; data = 8'h3C;
    out_ready = 1'b0; err_clr = 1'b0;

    // 1: reset with data_valid held high, then release
    cyc(); cyc();
    check("rst_data_read", 32'(data_read), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_full",      32'(full),      32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    reset_n = 1'b1;
    cyc();
    check("rel_dr_c2", 32'(data_read), 32'd1);
    sb.push_back(8'h3C);
    cyc();
    check("rel_dr_c3", 32'(data_read), 32'd1);
    cyc();
    check("rel_dr_c4", 32'(data_read), 32'd0);
    data_valid = 1'b0;
    cyc();
    drain();

    // 2: single transfer, data_valid held 5 cycles
    data = 8'hA5; data_valid = 1'b1;
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < 5; i++) begin
        cyc();
        if (data_read) hi++;
        if (i == 0) sb.push_back(8'hA5);
      end
      check("single_ack_len", 32'(hi), 32'd2);
    end
    check("single_dr_hold", 32'(data_read), 32'd0);
    data_valid = 1'b0;
    cyc();
    check("single_count",     32'(count),     32'd1);
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_data",  32'(out_data),  32'hA5);
    drain();

    // 3: fill to full, fifth word backpressured until a pop
    for (int i = 1; i <= 4; i++) xfer(DATA_W'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd4);
    data = 8'h05; data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("full_no_ack", 32'(data_read), 32'd0);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("pop_cycle_no_ack", 32'(data_read), 32'd0);
    check("pop_count", 32'(count), 32'd3);
    cyc();
    check("admit_after_pop", 32'(data_read), 32'd1);
    sb.push_back(8'h05);
    cyc(); cyc();
    check("fifth_released", 32'(data_read), 32'd0);
    data_valid = 1'b0;
    cyc();
    check("refill_count", 32'(count), 32'd4);
    drain();

    // 4: pointer wrap with the consumer always ready
    out_ready = 1'b1;
    track = 1'b1; max_cnt = 0;
    for (int i = 1; i <= 10; i++) xfer(DATA_W'(i));
    cyc(); cyc();
    track = 1'b0;
    check("wrap_max_count", 32'(max_cnt), 32'd1);
    check("wrap_proto_err", 32'(proto_err), 32'd0);
    drain();

    // 5: data_valid dropped in the second data_read cycle
    data = 8'h5A; data_valid = 1'b1;
    cyc();
    check("perr_dr1", 32'(data_read), 32'd1);
    sb.push_back(8'h5A);
    cyc();
    check("perr_dr2", 32'(data_read), 32'd1);
    data_valid = 1'b0;
    check("perr_before", 32'(proto_err), 32'd0);
    cyc();
    check("perr_set", 32'(proto_err), 32'd1);
    cyc();
    check("perr_sticky",   32'(proto_err), 32'd1);
    check("perr_stored",   32'(count),     32'd1);
    check("perr_out_data", 32'(out_data),  32'h5A);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("perr_clr", 32'(proto_err), 32'd0);
    drain();

    // 6: asynchronous reset in ACK with two words held
    xfer(8'h11);
    data = 8'h22; data_valid = 1'b1;
    cyc(); cyc();
    check("mid_state_ack", 32'(data_read), 32'd1);
    check("mid_count",     32'(count),     32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_count",     32'(count),     32'd0);
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_data_read", 32'(data_read), 32'd0);
    check("async_out_data",  32'(out_data),  32'd0);
    sb.delete();
    data_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    xfer(8'h77);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
